// File: rtl/beat_pattern_editor.sv
// Beat-pattern writer: debounced edit buttons with auto-repeat, live record, clear sweep.
// Owns the NUM_BEATS x 4-bit pattern register that playback reads.
module beat_pattern_editor #(
  parameter int CLK_FREQ        = 12_000_000,
  parameter int NUM_BEATS       = 16,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int REPEAT_DELAY    = 6_000_000,
  parameter int REPEAT_PERIOD   = 1_200_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_next,
  input  logic                         btn_prev,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_clear,
  input  logic                         rec_en,
  input  logic [3:0]                   rec_pitch,
  input  logic [$clog2(NUM_BEATS)-1:0] play_beat,
  output logic [NUM_BEATS*4-1:0]       beats,
  output logic [$clog2(NUM_BEATS)-1:0] cursor,
  output logic                         busy
);

  localparam int IW      = $clog2(NUM_BEATS);
  localparam int PW      = 4;
  localparam int NBTN    = 5;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RMAX + 1);
  localparam int B_CLEAR = 0;
  localparam int B_NEXT  = 1;
  localparam int B_PREV  = 2;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 4;

  if (NUM_BEATS < 2 || CLK_FREQ < 1) begin : g_param_check
    $error("beat_pattern_editor: NUM_BEATS must be >= 2 and CLK_FREQ positive");
  end

  typedef enum logic [0:0] {ST_EDIT = 1'b0, ST_CLEAR = 1'b1} state_t;

  logic [NBTN-1:0]  raw_s;
  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  level_q, level_d;
  logic [NBTN-1:0]  evt_q, evt_d;
  logic [DW-1:0]    db_cnt_q [NBTN];
  logic [DW-1:0]    db_cnt_d [NBTN];
  logic [RW-1:0]    rpt_cnt_q [B_NEXT:B_DOWN];
  logic [RW-1:0]    rpt_cnt_d [B_NEXT:B_DOWN];
  logic [B_DOWN:B_NEXT] rpt_first_q, rpt_first_d;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    cursor_q, cursor_d;
  logic [IW-1:0]    play_beat_q;
  logic [NUM_BEATS*PW-1:0] beats_q, beats_d;
  logic             busy_q, busy_d;

  logic             ev_clear_s, ev_next_s, ev_prev_s, ev_up_s, ev_down_s;
  logic             rec_wr_s, edit_wr_s;
  logic [PW-1:0]    cur_slot_s, edit_val_s;

  assign raw_s = {btn_down, btn_up, btn_prev, btn_next, btn_clear};

  // Button front end: synchronizers, accepted levels, debounce and repeat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      evt_q       <= '0;
      rpt_first_q <= '1;
      for (int b = 0; b < NBTN; b++) db_cnt_q[b] <= '0;
      for (int b = B_NEXT; b <= B_DOWN; b++) rpt_cnt_q[b] <= '0;
    end else begin
      sync1_q     <= raw_s;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      evt_q       <= evt_d;
      rpt_first_q <= rpt_first_d;
      for (int b = 0; b < NBTN; b++) db_cnt_q[b] <= db_cnt_d[b];
      for (int b = B_NEXT; b <= B_DOWN; b++) rpt_cnt_q[b] <= rpt_cnt_d[b];
    end
  end

  // Debounce plus auto-repeat; a repeat counter only runs while the accepted level is high
  always_comb begin
    level_d = level_q;
    evt_d   = '0;
    for (int b = 0; b < NBTN; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[b] = sync2_q[b];
          evt_d[b]   = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DW'(1);
        end
      end else begin
        db_cnt_d[b] = '0;
      end
    end
    for (int b = B_NEXT; b <= B_DOWN; b++) begin
      rpt_cnt_d[b]   = '0;
      rpt_first_d[b] = 1'b1;
      if (level_q[b]) begin
        if ((rpt_first_q[b] && rpt_cnt_q[b] == RW'(REPEAT_DELAY - 1)) ||
            (!rpt_first_q[b] && rpt_cnt_q[b] == RW'(REPEAT_PERIOD - 1))) begin
          evt_d[b]       = 1'b1;
          rpt_first_d[b] = 1'b0;
        end else begin
          rpt_cnt_d[b]   = rpt_cnt_q[b] + RW'(1);
          rpt_first_d[b] = rpt_first_q[b];
        end
      end else begin
        rpt_cnt_d[b]   = '0;
        rpt_first_d[b] = 1'b1;
      end
    end
  end

  assign ev_clear_s = evt_q[B_CLEAR];
  assign ev_next_s  = evt_q[B_NEXT] & ~evt_q[B_CLEAR];
  assign ev_prev_s  = evt_q[B_PREV] & ~(|evt_q[B_NEXT:B_CLEAR]);
  assign ev_up_s    = evt_q[B_UP]   & ~(|evt_q[B_PREV:B_CLEAR]);
  assign ev_down_s  = evt_q[B_DOWN] & ~(|evt_q[B_UP:B_CLEAR]);

  assign rec_wr_s   = rec_en & (play_beat != play_beat_q);
  assign cur_slot_s = beats_q[cursor_q*PW +: PW];
  assign edit_wr_s  = ev_up_s | ev_down_s;
  assign edit_val_s = ev_up_s ? (cur_slot_s + 4'd1) : (cur_slot_s - 4'd1);

  // FSM state register together with the pattern datapath and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EDIT;
      idx_q       <= '0;
      cursor_q    <= '0;
      play_beat_q <= '0;
      beats_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cursor_q    <= cursor_d;
      play_beat_q <= play_beat;
      beats_q     <= beats_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EDIT: begin
        if (ev_clear_s) state_d = ST_CLEAR;
        else            state_d = ST_EDIT;
      end
      ST_CLEAR: begin
        if (idx_q == IW'(NUM_BEATS - 1)) state_d = ST_EDIT;
        else                             state_d = ST_CLEAR;
      end
      default: state_d = ST_EDIT;
    endcase
  end

  // Output logic; a record write beats a same-slot up/down edit by priority order
  always_comb begin
    beats_d  = beats_q;
    cursor_d = cursor_q;
    idx_d    = idx_q;
    case (state_q)
      ST_EDIT: begin
        if (ev_clear_s) begin
          idx_d = '0;
        end else begin
          if (ev_next_s)      cursor_d = cursor_q + IW'(1);
          else if (ev_prev_s) cursor_d = cursor_q - IW'(1);
          else                cursor_d = cursor_q;
          for (int i = 0; i < NUM_BEATS; i++) begin
            if (rec_wr_s && play_beat == IW'(i))     beats_d[i*PW +: PW] = rec_pitch;
            else if (edit_wr_s && cursor_q == IW'(i)) beats_d[i*PW +: PW] = edit_val_s;
            else                                      beats_d[i*PW +: PW] = beats_q[i*PW +: PW];
          end
        end
      end
      ST_CLEAR: begin
        for (int i = 0; i < NUM_BEATS; i++) begin
          if (idx_q == IW'(i)) beats_d[i*PW +: PW] = 4'd0;
          else                 beats_d[i*PW +: PW] = beats_q[i*PW +: PW];
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_BEATS - 1)) cursor_d = '0;
        else                             cursor_d = cursor_q;
      end
      default: begin
        beats_d  = beats_q;
        cursor_d = cursor_q;
        idx_d    = idx_q;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  assign beats  = beats_q;
  assign cursor = cursor_q;
  assign busy   = busy_q;

endmodule

// File: doc/beat_pattern_editor.md
Name: beat_pattern_editor

Overview:
- Writer side of the sequencer's beat-pattern bus. It builds and holds the NUM_BEATS x 4-bit pattern that the playback controller reads, so playback and editing share one pattern register.
- User buttons move an edit cursor and change the pitch stored in each slot.
- An optional live-record mode writes an external pitch into the slot currently being played.
- A clear command sweeps every slot back to rest (pitch 0).

Parameters:
- CLK_FREQ, 12_000_000, system clock in Hz (informational; the timing parameters below are set in cycles).
- NUM_BEATS, 16, number of slots; power of two, at least 2.
- DEBOUNCE_CYCLES, 120_000, cycles a synced button must stay stable before its new level is accepted (10 ms).
- REPEAT_DELAY, 6_000_000, held cycles before auto-repeat starts.
- REPEAT_PERIOD, 1_200_000, cycles between auto-repeat events.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- btn_next  in  1  raw async button: cursor +1
- btn_prev  in  1  raw async button: cursor -1
- btn_up  in  1  raw async button: pitch +1 at cursor
- btn_down  in  1  raw async button: pitch -1 at cursor
- btn_clear  in  1  raw async button: clear the whole pattern
- rec_en  in  1  live-record enable (synchronous to clk)
- rec_pitch  in  4  pitch to record (synchronous to clk)
- play_beat  in  $clog2(NUM_BEATS)  current playback slot from the controller
- beats  out  NUM_BEATS*4  pattern; slot i occupies bits [i*4 +: 4]
- cursor  out  $clog2(NUM_BEATS)  current edit slot
- busy  out  1  high while a clear sweep is in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - beats = 0, cursor = 0, busy = 0, FSM = EDIT.
  - All synchronizer, debounce and repeat counters = 0; the accepted button level = 0.
  - Release of reset is not required to be synchronized inside the block.
- Button front end, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synced level differs from the accepted level and resets to 0 when they match. On reaching DEBOUNCE_CYCLES-1 the accepted level updates.
  - An event pulse (1 cycle) fires on the accepted 0->1 transition.
  - next/prev/up/down only: while held, a repeat counter runs. The first repeat fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles. Release resets the counter.
  - clear has no auto-repeat.
- Event arbitration, at most one edit event per cycle:
  - Priority: clear > next > prev > up > down.
  - Losing events in the same cycle are dropped, not queued.
- FSM EDIT:
  - next: cursor = cursor+1, wrapping NUM_BEATS-1 -> 0.
  - prev: cursor = cursor-1, wrapping 0 -> NUM_BEATS-1.
  - up: slot[cursor] = slot[cursor]+1, modulo 16 (15 -> 0).
  - down: slot[cursor] = slot[cursor]-1, modulo 16 (0 -> 15).
  - clear: go to CLEAR, set busy=1, load the sweep index with 0.
- FSM CLEAR:
  - Each cycle writes slot[index] = 0 and increments index.
  - After the cycle that writes slot NUM_BEATS-1: cursor = 0, busy = 0, FSM = EDIT.
  - Sweep length is exactly NUM_BEATS cycles.
  - All button events and record writes during CLEAR are dropped.
- Live record (EDIT only):
  - play_beat is registered every cycle. A record write fires when rec_en = 1 and play_beat differs from its registered value.
  - The write is slot[play_beat] = rec_pitch, as sampled in the change cycle.
  - Record and a button edit may both write in the same cycle if they target different slots.
  - If both target the same slot, the record write wins and the up/down edit is discarded.
  - A cursor move in the same cycle as a record write is always applied.
- Latency:
  - All writes are visible on beats the cycle after the event pulse; cursor likewise.
  - Button press to event pulse = 2 sync cycles + DEBOUNCE_CYCLES.
- Outputs are registered; there is no combinational path from any input to beats, cursor or busy.
- Asserting rst_n mid-sweep aborts the sweep; beats = 0 anyway.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, NUM_BEATS=16):
- Reset, then 3 clean btn_up presses, btn_next, 1 btn_down:
  - slot0 = 3, slot1 = 15, cursor = 1, all other slots 0.
- Bounce btn_next high/low every 2 cycles for 20 cycles, then hold high 10 cycles:
  - exactly one cursor increment.
- Hold btn_up for 40 cycles after the press event:
  - events at press, +20, +25, +30, +35, giving slot[cursor] = 5.
- cursor=0 with btn_prev; cursor=15 with btn_next:
  - cursor goes 0 -> 15 and 15 -> 0.
  - slot=15 with btn_up gives 0.
- Fill slots with 0xA, then press btn_clear:
  - busy high for exactly 16 cycles; beats = 0 after; cursor = 0.
  - btn_up events during the sweep are lost.
- rec_en=1, rec_pitch=7, play_beat stepping 0..3, with btn_up pulsed at cursor=2 in the cycle play_beat becomes 2:
  - slots 0..3 = 7 (record wins on slot 2).
  - With rec_en=0 and play_beat changing, beats is unchanged.
